// File: rtl/score_keeper_if.sv
// Game-side signal bundle for score_keeper: play controls in, BCD score and status out.
interface score_keeper_if;
  logic       game_en;
  logic       guess_strobe;
  logic [1:0] sum_status;
  logic       timeout;
  logic [3:0] score_tens;
  logic [3:0] score_ones;
  logic [3:0] rounds_left;
  logic       game_over;
  logic       win_pulse;
  logic       lose_pulse;
  logic [3:0] best_streak;

  modport master (
    output game_en, guess_strobe, sum_status, timeout,
    input  score_tens, score_ones, rounds_left, game_over, win_pulse, lose_pulse, best_streak
  );
  modport slave (
    input  game_en, guess_strobe, sum_status, timeout,
    output score_tens, score_ones, rounds_left, game_over, win_pulse, lose_pulse, best_streak
  );
endinterface

// File: rtl/score_keeper.sv
// Round/score FSM for the guessing game: BCD score with saturation, round countdown, win/lose pulses.
// Optional longest-win-streak tracking is enabled by defining SCORE_KEEPER_STREAK_EN.
module score_keeper #(
  parameter int MAX_ROUNDS = 9,
  parameter int SCORE_MAX  = 99
) (
  input logic          CLOCK,
  input logic          RESET,
  score_keeper_if.slave bus
);
  localparam logic [3:0] MAX_T       = 4'(SCORE_MAX / 10);
  localparam logic [3:0] MAX_O       = 4'(SCORE_MAX % 10);
  localparam logic [3:0] ROUNDS_INIT = 4'(MAX_ROUNDS);

  typedef enum logic [1:0] {IDLE, PLAY, EVAL, OVER} state_t;
  state_t state;

  logic [3:0] tens_q, ones_q, rounds_q;
  logic       over_q, win_q, lose_q;
  logic       below_max, is_win, is_lose;
  logic [3:0] rounds_dec;

  // BCD compare against the ceiling avoids a binary conversion
  assign below_max  = (tens_q < MAX_T) || ((tens_q == MAX_T) && (ones_q < MAX_O));
  assign rounds_dec = rounds_q - 4'd1;
  assign is_win     = (bus.sum_status == 2'b01);
  assign is_lose    = (bus.sum_status == 2'b10);

`ifdef SCORE_KEEPER_STREAK_EN
  logic [3:0] cur_q, best_q, cur_inc;
  assign cur_inc = (cur_q == 4'd15) ? cur_q : cur_q + 4'd1;
`endif

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state    <= IDLE;
      tens_q   <= '0;
      ones_q   <= '0;
      rounds_q <= '0;
      over_q   <= 1'b0;
      win_q    <= 1'b0;
      lose_q   <= 1'b0;
`ifdef SCORE_KEEPER_STREAK_EN
      cur_q    <= '0;
      best_q   <= '0;
`endif
    end else begin
      win_q  <= 1'b0;
      lose_q <= 1'b0;
      case (state)
        IDLE: if (bus.game_en) begin
          state    <= PLAY;
          tens_q   <= '0;
          ones_q   <= '0;
          rounds_q <= ROUNDS_INIT;
`ifdef SCORE_KEEPER_STREAK_EN
          cur_q    <= '0;
          best_q   <= '0;
`endif
        end
        PLAY: begin
          if (!bus.game_en) state <= IDLE;
          else if (bus.timeout) begin
            state  <= OVER;
            over_q <= 1'b1;
`ifdef SCORE_KEEPER_STREAK_EN
            cur_q  <= '0;
`endif
          end else if (bus.guess_strobe) state <= EVAL;
        end
        EVAL: begin
          if (!bus.game_en) state <= IDLE;
          else if (bus.timeout) begin
            state  <= OVER;
            over_q <= 1'b1;
`ifdef SCORE_KEEPER_STREAK_EN
            cur_q  <= '0;
`endif
          end else if (is_win || is_lose) begin
            rounds_q <= rounds_dec;
            if (rounds_dec == 4'd0) begin
              state  <= OVER;
              over_q <= 1'b1;
            end else state <= PLAY;
            if (is_win) begin
              win_q <= 1'b1;
              if (below_max) begin
                if (ones_q == 4'd9) begin
                  ones_q <= '0;
                  tens_q <= tens_q + 4'd1;
                end else ones_q <= ones_q + 4'd1;
              end
`ifdef SCORE_KEEPER_STREAK_EN
              cur_q <= cur_inc;
              if (cur_inc > best_q) best_q <= cur_inc;
`endif
            end else begin
              lose_q <= 1'b1;
`ifdef SCORE_KEEPER_STREAK_EN
              cur_q  <= '0;
`endif
            end
          end else state <= PLAY;
        end
        OVER: if (!bus.game_en) begin
          state  <= IDLE;
          over_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.score_tens  = tens_q;
  assign bus.score_ones  = ones_q;
  assign bus.rounds_left = rounds_q;
  assign bus.game_over   = over_q;
  assign bus.win_pulse   = win_q;
  assign bus.lose_pulse  = lose_q;
`ifdef SCORE_KEEPER_STREAK_EN
  assign bus.best_streak = best_q;
`else
  assign bus.best_streak = 4'd0;
`endif
endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 SHALL have parameter MAX_ROUNDS, default 9, meaning the number of scored rounds per game (legal range 1-15).
REQ-002 SHALL have parameter SCORE_MAX, default 99, meaning the BCD saturation ceiling of the score (legal range 1-99).
REQ-003 SHALL have port CLOCK  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port RESET  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port game_en  input  1  level; high while the access controller grants play.
REQ-006 SHALL have port guess_strobe  input  1  one-cycle pulse when the player number register loads.
REQ-007 SHALL have port sum_status  input  2  checker result: 01 = win, 10 = lose, 00 or 11 = neutral.
REQ-008 SHALL have port timeout  input  1  level or pulse from the digit timer; high means time expired.
REQ-009 SHALL have port score_tens  output  4  BCD tens digit of the score, for decoder7.
REQ-010 SHALL have port score_ones  output  4  BCD ones digit of the score, for decoder7.
REQ-011 SHALL have port rounds_left  output  4  binary count of remaining rounds.
REQ-012 SHALL have port game_over  output  1  level; high in the OVER state.
REQ-013 SHALL have port win_pulse  output  1  one-cycle pulse per scored win.
REQ-014 SHALL have port lose_pulse  output  1  one-cycle pulse per scored loss.
REQ-015 SHALL have port best_streak  output  4  binary longest win streak in the current game (see Configuration).

Function
REQ-016 SHALL implement a 4-state FSM: IDLE, PLAY, EVAL, OVER.
REQ-017 In IDLE, game_en high SHALL move the FSM to PLAY, clear the score to 00, and load rounds_left with MAX_ROUNDS on that same edge.
REQ-018 In PLAY, guess_strobe high with timeout low SHALL move the FSM to EVAL.
REQ-019 In EVAL, the FSM SHALL sample sum_status exactly once (one cycle after the strobe, when the adder and checker have settled), then leave EVAL on the next edge.
REQ-020 A win SHALL increment the BCD score (ones 9 wraps to 0 with a tens carry), saturate at SCORE_MAX, decrement rounds_left, and assert win_pulse for the cycle that follows.
REQ-021 A lose SHALL decrement rounds_left and assert lose_pulse for the cycle that follows; the score SHALL be unchanged.
REQ-022 A neutral result SHALL leave the score and rounds_left unchanged, assert no pulse, and return the FSM to PLAY.
REQ-023 After a win or lose, the FSM SHALL go to OVER if the decremented rounds_left is 0; otherwise it SHALL return to PLAY.
REQ-024 timeout high in PLAY or EVAL SHALL move the FSM to OVER and take priority over guess_strobe and sum_status in the same cycle; no score change or pulse occurs.
REQ-025 guess_strobe SHALL be ignored in EVAL, OVER, and IDLE.
REQ-026 game_en low in PLAY or EVAL SHALL move the FSM to IDLE with the score and rounds_left held; no pulse occurs.
REQ-027 In OVER, game_over SHALL be 1 and all counters SHALL be frozen; game_en low SHALL move the FSM to IDLE.
REQ-028 win_pulse and lose_pulse SHALL never be high in the same cycle.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 RESET high at a rising edge SHALL force IDLE, score 00, rounds_left 0, best_streak 0, game_over 0, and win_pulse and lose_pulse 0.
REQ-031 RESET SHALL override every other input, including mid-EVAL and mid-pulse; a pending evaluation SHALL be discarded.

Configuration
REQ-032 Macro SCORE_KEEPER_STREAK_EN defined: the block SHALL keep a current-streak counter that increments on a win and clears on a lose or timeout; best_streak SHALL update to max(best, current) and saturate at 15. It SHALL be cleared on IDLE to PLAY.
REQ-033 Macro SCORE_KEEPER_STREAK_EN undefined: no streak logic SHALL be synthesized; best_streak SHALL be driven constant 0 and the port SHALL remain.

Verification
REQ-034 Reset, raise game_en, then 3 guesses with sum_status = 01 -> score 03, rounds_left 6, three win_pulses, each 1 cycle wide and 1 cycle after EVAL.
REQ-035 Set MAX_ROUNDS = 2, then play win followed by lose -> game_over = 1 after the second evaluation, score 01, and further strobes ignored.
REQ-036 Set SCORE_MAX = 10 with a preloaded score of 09, then 2 wins -> score 10 and then stays 10; rounds_left still decrements.
REQ-037 Assert guess_strobe and timeout in the same PLAY cycle -> OVER, no pulse, score unchanged; drop game_en -> IDLE.
REQ-038 Assert RESET in the EVAL cycle with sum_status = 01 -> the next cycle shows IDLE, score 00, and no win_pulse.
REQ-039 With SCORE_KEEPER_STREAK_EN defined, play win, win, lose, win -> best_streak 2; with it undefined -> best_streak 0 throughout.
